mem_stage_lsu: RTL

Parametrised memory stage of the RV32I pipeline: EX/MEM pipeline register plus a load/store unit and word-organised data memory. It adds byte/halfword access with byte-enables, sign/zero extension, misalignment detection, stall/flush of the stage register, and an optional synchronous-read memory mode with a two-state wait FSM and a stall request. It sits between the execute stage and the MEM/WB register; its M-stage outputs feed the writeback mux and the hazard/forwarding unit.

---
 rtl/mem_stage_lsu_if.sv | 42 ++++
 rtl/mem_stage_lsu.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu_if.sv
// EX->MEM stage bundle: execute-side control/data, stage stall/flush, and the
// registered M-stage outputs consumed by writeback and the hazard unit.
interface mem_stage_lsu_if #(parameter int XLEN = 32);
  logic            StallM;
  logic            FlushM;
  logic            RegWriteE;
  logic            MemWriteE;
  logic            MemReadE;
  logic [1:0]      ResultSrcE;
  logic [2:0]      Funct3E;
  logic [XLEN-1:0] ALUResultE;
  logic [XLEN-1:0] WriteDataE;
  logic [XLEN-1:0] PCPlus4E;
  logic [4:0]      RdE;

  logic            RegWriteM;
  logic            MemWriteM;
  logic            MemReadM;
  logic [1:0]      ResultSrcM;
  logic [2:0]      Funct3M;
  logic [4:0]      RdM;
  logic [XLEN-1:0] ALUResultM;
  logic [XLEN-1:0] WriteDataM;
  logic [XLEN-1:0] PCPlus4M;
  logic [XLEN-1:0] ReadDataM;
  logic            MisalignedM;
  logic            BusyM;

  modport master (
    output StallM, FlushM, RegWriteE, MemWriteE, MemReadE, ResultSrcE, Funct3E,
           ALUResultE, WriteDataE, PCPlus4E, RdE,
    input  RegWriteM, MemWriteM, MemReadM, ResultSrcM, Funct3M, RdM,
           ALUResultM, WriteDataM, PCPlus4M, ReadDataM, MisalignedM, BusyM
  );

  modport slave (
    input  StallM, FlushM, RegWriteE, MemWriteE, MemReadE, ResultSrcE, Funct3E,
           ALUResultE, WriteDataE, PCPlus4E, RdE,
    output RegWriteM, MemWriteM, MemReadM, ResultSrcM, Funct3M, RdM,
           ALUResultM, WriteDataM, PCPlus4M, ReadDataM, MisalignedM, BusyM
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// RV32I memory stage: EX/MEM register, byte/half/word load-store unit and a
// word-organised data memory with optional registered read and stall request.
module mem_stage_lsu #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 256,
  parameter int SYNC_READ = 0
) (
  input  logic           clk,
  input  logic           rst,
  mem_stage_lsu_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic            regwrite;
    logic            memwrite;
    logic            memread;
    logic [1:0]      result_src;
    logic [2:0]      funct3;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rd;
  } exmem_t;

  typedef enum logic {IDLE, DONE} rd_state_e;

  exmem_t          m_q;
  logic            busy;
  logic [XLEN-1:0] mem [DEPTH];
  logic [XLEN-1:0] mem_word;
  logic [XLEN-1:0] raw_word;
  logic [AW-1:0]   widx;
  logic [1:0]      boff;
  logic            is_half, is_word, misaligned;
  logic [3:0]      be;
  logic [XLEN-1:0] st_data;
  logic            we;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;
  logic [XLEN-1:0] load_data;

  // Flush beats both stall sources; a busy load holds the register like a stall.
  always_ff @(posedge clk) begin
    if (rst || bus.FlushM) begin
      m_q <= '0;
    end else if (!(bus.StallM || busy)) begin
      m_q <= '{regwrite:   bus.RegWriteE,
               memwrite:   bus.MemWriteE,
               memread:    bus.MemReadE,
               result_src: bus.ResultSrcE,
               funct3:     bus.Funct3E,
               alu_result: bus.ALUResultE,
               write_data: bus.WriteDataE,
               pc_plus4:   bus.PCPlus4E,
               rd:         bus.RdE};
    end
  end

  assign widx       = m_q.alu_result[AW+1:2];
  assign boff       = m_q.alu_result[1:0];
  assign is_half    = (m_q.funct3[1:0] == 2'b01);
  assign is_word    = (m_q.funct3 == 3'b010);
  assign misaligned = (m_q.memread || m_q.memwrite) &&
                      ((is_half && boff[0]) || (is_word && (boff != 2'b00)));

  always_comb begin
    be      = 4'b0000;
    st_data = m_q.write_data;
    case (m_q.funct3)
      3'b000: begin
        be      = 4'b0001 << boff;
        st_data = {4{m_q.write_data[7:0]}};
      end
      3'b001: begin
        be      = boff[1] ? 4'b1100 : 4'b0011;
        st_data = {2{m_q.write_data[15:0]}};
      end
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign we = m_q.memwrite && !misaligned && !rst;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we && be[b]) mem[widx][8*b +: 8] <= st_data[8*b +: 8];
    end
  end

  assign mem_word = mem[widx];

  generate
    if (SYNC_READ != 0) begin : g_sync
      rd_state_e       state, state_next;
      logic [XLEN-1:0] rd_buf;

      always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
      end

      // One wait cycle per load: IDLE requests the stall, DONE serves the data.
      always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
          IDLE: begin
            if (m_q.memread && !bus.FlushM) begin
              busy       = 1'b1;
              state_next = DONE;
            end
          end
          DONE: begin
            if (bus.FlushM || !bus.StallM) state_next = IDLE;
          end
          default: state_next = IDLE;
        endcase
      end

      always_ff @(posedge clk) begin
        if (rst)       rd_buf <= '0;
        else if (busy) rd_buf <= mem_word;
      end

      assign raw_word = rd_buf;
    end else begin : g_comb
      assign busy     = 1'b0;
      assign raw_word = mem_word;
    end
  endgenerate

  assign lane_b = raw_word[{boff, 3'b000} +: 8];
  assign lane_h = boff[1] ? raw_word[31:16] : raw_word[15:0];

  always_comb begin
    load_data = raw_word;
    case (m_q.funct3)
      3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
      3'b100:  load_data = {24'h0, lane_b};
      3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
      3'b101:  load_data = {16'h0, lane_h};
      default: load_data = raw_word;
    endcase
    // Nothing meaningful to return without a load, or while still waiting on it.
    if (!m_q.memread || busy) load_data = '0;
  end

  assign bus.RegWriteM   = m_q.regwrite && !(m_q.memread && misaligned);
  assign bus.MemWriteM   = m_q.memwrite;
  assign bus.MemReadM    = m_q.memread;
  assign bus.ResultSrcM  = m_q.result_src;
  assign bus.Funct3M     = m_q.funct3;
  assign bus.RdM         = m_q.rd;
  assign bus.ALUResultM  = m_q.alu_result;
  assign bus.WriteDataM  = m_q.write_data;
  assign bus.PCPlus4M    = m_q.pc_plus4;
  assign bus.ReadDataM   = load_data;
  assign bus.MisalignedM = misaligned;
  assign bus.BusyM       = busy;
endmodule
